// File: rtl/packet_depicker.sv
// Receive-side HDMI data-island packet parser: ACR N/CTS, audio sample FIFO, AVI VIC, InfoFrame checksum.
// Optional per-sample parity scrubbing is enabled by defining PACKET_DEPICKER_PARITY_CHECK_EN.
module packet_depicker #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                                clk_pixel,
  input  logic                                reset_n,
  input  logic                                packet_valid,
  input  logic [23:0]                         header,
  input  logic [3:0][55:0]                    sub,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0]     audio_sample_word,
  output logic                                audio_block_start,
  output logic                                audio_valid,
  input  logic                                audio_ready,
  output logic [$clog2(FIFO_DEPTH):0]         audio_fifo_level,
  output logic [19:0]                         acr_n,
  output logic [19:0]                         acr_cts,
  output logic                                acr_update,
  output logic [6:0]                          video_id_code,
  output logic                                avi_valid,
  output logic                                checksum_error,
  output logic                                overflow,
  output logic                                packet_drop,
  output logic [15:0]                         parity_error_count
);

  localparam int W  = AUDIO_BIT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_UNPACK} state_t;

  state_t r_state, w_next_state;

  logic [1:0]          r_idx;
  logic [3:0]          r_present, r_flat, r_bflag;
  logic [3:0][W-1:0]   r_word_l, r_word_r;
  logic [19:0]         r_acr_n, r_acr_cts;
  logic [6:0]          r_vic;
  logic                r_acr_update, r_avi_valid, r_checksum_error, r_overflow, r_packet_drop;

  logic [W-1:0]        r_mem_l [FIFO_DEPTH];
  logic [W-1:0]        r_mem_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_b;
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_level;

  logic                w_accept, w_is_acr, w_is_audio, w_is_info, w_acr_same;
  logic [2:0]          w_popcnt;
  logic [LW-1:0]       w_free;
  logic                w_no_room;
  logic [7:0]          w_sum;
  logic                w_wr_en, w_rd_en;
  logic [W-1:0]        w_pass_l, w_pass_r, w_wr_l, w_wr_r;

  // ---------------- packet decode (evaluated on the strobe cycle) ----------------
  assign w_accept   = packet_valid && (r_state == S_IDLE);
  assign w_is_acr   = (header[7:0] == 8'h01);
  assign w_is_audio = (header[7:0] == 8'h02);
  assign w_is_info  = header[7];
  assign w_acr_same = (sub[1] == sub[0]) && (sub[2] == sub[0]) && (sub[3] == sub[0]);

  assign w_popcnt  = {2'b00, header[8]} + {2'b00, header[9]} + {2'b00, header[10]} + {2'b00, header[11]};
  assign w_free    = LW'(FIFO_DEPTH) - r_level;
  assign w_no_room = LW'(w_popcnt) > w_free;

  always_comb begin
    w_sum = header[7:0] + header[15:8] + header[23:16];
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 7; j++) begin
        w_sum = w_sum + sub[k][8*j +: 8];
      end
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned and infers a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_is_audio && !w_no_room) w_next_state = S_UNPACK;
      S_UNPACK: if (r_idx == 2'd3) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // ---------------- unpack datapath ----------------
  assign w_wr_en  = (r_state == S_UNPACK) && r_present[r_idx];
  assign w_rd_en  = (r_level != '0) && audio_ready;
  assign w_pass_l = r_flat[r_idx] ? '0 : r_word_l[r_idx];
  assign w_pass_r = r_flat[r_idx] ? '0 : r_word_r[r_idx];

`ifdef PACKET_DEPICKER_PARITY_CHECK_EN
  logic [3:0]   r_bad;
  logic [W-1:0] r_last_l, r_last_r;
  logic [15:0]  r_par_cnt;

  // A pair failing parity on either channel is concealed with the last good pair.
  assign w_wr_l = r_bad[r_idx] ? r_last_l : w_pass_l;
  assign w_wr_r = r_bad[r_idx] ? r_last_r : w_pass_r;
  assign parity_error_count = r_par_cnt;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_bad     <= '0;
      r_last_l  <= '0;
      r_last_r  <= '0;
      r_par_cnt <= '0;
    end else begin
      if (w_accept && w_is_audio && !w_no_room) begin
        for (int i = 0; i < 4; i++) begin
          r_bad[i] <= (^{sub[i][51:48], sub[i][23:0]}) | (^{sub[i][55:52], sub[i][47:24]});
        end
      end
      if (w_wr_en) begin
        if (r_bad[r_idx]) begin
          if (r_par_cnt != 16'hFFFF) r_par_cnt <= r_par_cnt + 16'd1;
        end else begin
          r_last_l <= w_pass_l;
          r_last_r <= w_pass_r;
        end
      end
    end
  end
`else
  assign w_wr_l = w_pass_l;
  assign w_wr_r = w_pass_r;
  assign parity_error_count = '0;
`endif

  // ---------------- registered state and pulses ----------------
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_idx            <= '0;
      r_present        <= '0;
      r_flat           <= '0;
      r_bflag          <= '0;
      r_word_l         <= '0;
      r_word_r         <= '0;
      r_acr_n          <= '0;
      r_acr_cts        <= '0;
      r_vic            <= '0;
      r_acr_update     <= 1'b0;
      r_avi_valid      <= 1'b0;
      r_checksum_error <= 1'b0;
      r_overflow       <= 1'b0;
      r_packet_drop    <= 1'b0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
    end else begin
      r_acr_update     <= 1'b0;
      r_checksum_error <= 1'b0;
      r_overflow       <= 1'b0;
      r_packet_drop    <= packet_valid && (r_state == S_UNPACK);
      r_idx            <= (r_state == S_UNPACK) ? r_idx + 2'd1 : 2'd0;

      if (w_accept) begin
        if (w_is_acr && w_acr_same) begin
          r_acr_cts    <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
          r_acr_n      <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
          r_acr_update <= 1'b1;
        end
        if (w_is_audio) begin
          if (w_no_room) begin
            r_overflow <= 1'b1;
          end else begin
            r_present <= header[11:8];
            r_flat    <= header[19:16];
            r_bflag   <= header[23:20];
            for (int i = 0; i < 4; i++) begin
              r_word_l[i] <= sub[i][23 -: W];
              r_word_r[i] <= sub[i][47 -: W];
            end
          end
        end
        if (w_is_info) begin
          if (w_sum != 8'h00) begin
            r_checksum_error <= 1'b1;
          end else if (header[7:0] == 8'h82) begin
            r_vic       <= sub[0][38:32];
            r_avi_valid <= 1'b1;
          end
        end
      end

      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the head is masked by audio_valid so stale contents never leak out.
  always_ff @(posedge clk_pixel) begin
    if (w_wr_en) begin
      r_mem_l[r_wr_ptr] <= w_wr_l;
      r_mem_r[r_wr_ptr] <= w_wr_r;
      r_mem_b[r_wr_ptr] <= r_bflag[r_idx];
    end
  end

  // ---------------- outputs ----------------
  assign audio_valid          = (r_level != '0);
  assign audio_sample_word[0] = audio_valid ? r_mem_l[r_rd_ptr] : '0;
  assign audio_sample_word[1] = audio_valid ? r_mem_r[r_rd_ptr] : '0;
  assign audio_block_start    = audio_valid & r_mem_b[r_rd_ptr];
  assign audio_fifo_level     = r_level;
  assign acr_n                = r_acr_n;
  assign acr_cts              = r_acr_cts;
  assign acr_update           = r_acr_update;
  assign video_id_code        = r_vic;
  assign avi_valid            = r_avi_valid;
  assign checksum_error       = r_checksum_error;
  assign overflow             = r_overflow;
  assign packet_drop          = r_packet_drop;

endmodule
